sprite_slot_sequencer: RTL and testbench

Per-line sprite walker for the draw-clock pipeline, generalising the fixed sprite-index/tile-slot sequencing. On each line pulse it walks sprite indices 0..NUM_SPRITES-1 through a request/response sprite matcher. For every hit it emits one half-tile slot per 4 source pixels on a valid/ready stream towards the tile-map/tile BRAM fetch stages, with parametrised widths, backpressure and an optional per-line sprite limit.

---
 rtl/sprite_slot_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_sprite_slot_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_slot_sequencer.sv
// sprite_slot_sequencer
//   Per-line sprite walker for the draw-clock pipeline. On each line pulse it
//   walks sprite indices 0..NUM_SPRITES-1 through a request/response sprite
//   matcher and, for every hit, emits one half-tile slot per 4 source pixels
//   on a valid/ready stream towards the tile-map / tile BRAM fetch stages.
//
//   Optional feature: define SPRITE_SEQ_LIMIT_EN to cap hits per line at
//   MAX_PER_LINE (overflow_o flags a truncated line).
//
// Ports
//   clk_draw, rst_draw_n   draw clock, async active-low reset
//   line_i, enable_i       start-of-line pulse, run enable
//   match_*                request/response sprite matcher interface
//   slot_*                 valid/ready slot stream (lbx, map, bmp, half, last)
//   busy_o                 walk in progress (not IDLE/DONE)
//   line_done_o            one-cycle pulse on entering DONE
//   overflow_o             per-line hit limit reached (0 without the limit)
module sprite_slot_sequencer #(
    parameter int unsigned NUM_SPRITES  = 512,
    parameter int unsigned CNT_W        = 7,
    parameter int unsigned LBX_W        = 12,
    parameter int unsigned MAP_W        = 10,
    parameter int unsigned BMP_W        = 14,
    parameter int unsigned STEP         = 8,
    parameter int unsigned MAX_PER_LINE = 64,
    localparam int unsigned IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic             clk_draw,
    input  logic             rst_draw_n,
    input  logic             line_i,
    input  logic             enable_i,
    output logic             match_req_o,
    output logic [IDX_W-1:0] match_idx_o,
    input  logic             match_valid_i,
    input  logic             match_hit_i,
    input  logic [CNT_W-1:0] match_count_i,
    input  logic [LBX_W-1:0] match_lbx_i,
    input  logic [MAP_W-1:0] match_map_i,
    input  logic [BMP_W-1:0] match_bmp_i,
    output logic             slot_valid_o,
    input  logic             slot_ready_i,
    output logic [LBX_W-1:0] slot_lbx_o,
    output logic [MAP_W-1:0] slot_map_o,
    output logic [BMP_W-1:0] slot_bmp_o,
    output logic             slot_half_o,
    output logic             slot_last_o,
    output logic             busy_o,
    output logic             line_done_o,
    output logic             overflow_o
);

    localparam int unsigned      SLOT_W   = CNT_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DRAIN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LBX_W-1:0]    lbx_q;
    logic [MAP_W-1:0]    map_q;
    logic [BMP_W-1:0]    bmp_q;
    logic                drain_idle_q, drain_idle_d;
    logic                ovf_q;

    logic restart, idx_inc, latch, slot_step, adv, set_ovf, hit_inc;
    logic handshake, last_slot;

`ifdef SPRITE_SEQ_LIMIT_EN
    localparam int unsigned HITS_W = $clog2(MAX_PER_LINE + 1);
    logic [HITS_W-1:0] hits_q;
    logic              limit_reached;
    assign limit_reached = (hits_q + HITS_W'(1)) == HITS_W'(MAX_PER_LINE);
`endif

    assign handshake = (state_q == EMIT) && slot_ready_i;
    assign last_slot = slot_q == ({cnt_q, 1'b0} - SLOT_W'(1));

    always_comb begin
        state_d      = state_q;
        drain_idle_d = drain_idle_q;
        restart      = 1'b0;
        idx_inc      = 1'b0;
        latch        = 1'b0;
        slot_step    = 1'b0;
        adv          = 1'b0;
        set_ovf      = 1'b0;
        hit_inc      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (line_i && enable_i) begin
                    restart = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The request is only registered when FETCH hands over to
                // WAIT, so leaving FETCH any other way leaves nothing in flight.
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (line_i) begin
                    restart = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response arriving in the same cycle as an abort is
                // already consumed, so DRAIN is only needed when it is not.
                if (!enable_i) begin
                    drain_idle_d = 1'b1;
                    state_d      = match_valid_i ? IDLE : DRAIN;
                end else if (line_i) begin
                    restart      = 1'b1;
                    drain_idle_d = 1'b0;
                    state_d      = match_valid_i ? FETCH : DRAIN;
                end else if (match_valid_i) begin
                    if (match_hit_i && (match_count_i != '0)) begin
                        latch   = 1'b1;
                        state_d = EMIT;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            EMIT: begin
                hit_inc = handshake && last_slot;
                if (!enable_i) begin
                    if (handshake) begin
                        state_d = IDLE;
                    end
                end else if (line_i) begin
                    restart = 1'b1;
                    state_d = FETCH;
                end else if (handshake) begin
                    if (last_slot) begin
                        adv = 1'b1;
                    end else begin
                        slot_step = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!enable_i) begin
                    drain_idle_d = 1'b1;
                end else if (line_i) begin
                    restart      = 1'b1;
                    drain_idle_d = 1'b0;
                end
                if (match_valid_i) begin
                    state_d = drain_idle_d ? IDLE : FETCH;
                end
            end
            DONE: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (line_i) begin
                    restart = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
`ifdef SPRITE_SEQ_LIMIT_EN
            if (hit_inc && limit_reached) begin
                state_d = DONE;
                set_ovf = idx_q != IDX_LAST;
            end else
`endif
            if (idx_q == IDX_LAST) begin
                state_d = DONE;
            end else begin
                idx_inc = 1'b1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            slot_q       <= '0;
            cnt_q        <= '0;
            lbx_q        <= '0;
            map_q        <= '0;
            bmp_q        <= '0;
            drain_idle_q <= 1'b0;
            ovf_q        <= 1'b0;
            match_req_o  <= 1'b0;
            line_done_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_idle_q <= drain_idle_d;
            match_req_o  <= (state_q == FETCH) && (state_d == WAIT);
            line_done_o  <= (state_d == DONE) && (state_q != DONE);

            if (restart) begin
                idx_q <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + IDX_W'(1);
            end

            if (restart) begin
                ovf_q <= 1'b0;
            end else if (set_ovf) begin
                ovf_q <= 1'b1;
            end

            if (latch) begin
                cnt_q  <= match_count_i;
                lbx_q  <= match_lbx_i;
                map_q  <= match_map_i;
                bmp_q  <= match_bmp_i;
                slot_q <= '0;
            end else if (slot_step) begin
                slot_q <= slot_q + SLOT_W'(1);
                lbx_q  <= lbx_q + LBX_W'(STEP);
            end
        end
    end

`ifdef SPRITE_SEQ_LIMIT_EN
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            hits_q <= '0;
        end else if (restart) begin
            hits_q <= '0;
        end else if (hit_inc) begin
            hits_q <= hits_q + HITS_W'(1);
        end
    end
    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign match_idx_o  = idx_q;
    assign slot_valid_o = state_q == EMIT;
    assign slot_last_o  = slot_valid_o && last_slot;
    assign slot_half_o  = slot_q[0];
    assign slot_lbx_o   = lbx_q;
    assign slot_bmp_o   = bmp_q;
    // Two half-tile slots share one tile-map entry.
    assign slot_map_o   = map_q + MAP_W'(slot_q[SLOT_W-1:1]);
    assign busy_o       = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_sprite_slot_sequencer.sv
module tb_sprite_slot_sequencer;

    localparam int unsigned NS = 512;
    localparam int unsigned CW = 7;
    localparam int unsigned LW = 12;
    localparam int unsigned MW = 10;
    localparam int unsigned BW = 14;

    typedef logic [LW+MW+BW+1:0] slot_t;

    logic          clk_draw = 1'b0;
    logic          rst_draw_n;
    logic          line_i, enable_i;
    logic          match_req_o;
    logic [8:0]    match_idx_o;
    logic          match_valid_i, match_hit_i;
    logic [CW-1:0] match_count_i;
    logic [LW-1:0] match_lbx_i;
    logic [MW-1:0] match_map_i;
    logic [BW-1:0] match_bmp_i;
    logic          slot_valid_o, slot_ready_i;
    logic [LW-1:0] slot_lbx_o;
    logic [MW-1:0] slot_map_o;
    logic [BW-1:0] slot_bmp_o;
    logic          slot_half_o, slot_last_o;
    logic          busy_o, line_done_o, overflow_o;

    always #5 clk_draw = ~clk_draw;

    sprite_slot_sequencer #(
        .NUM_SPRITES (NS),
        .CNT_W       (CW),
        .LBX_W       (LW),
        .MAP_W       (MW),
        .BMP_W       (BW),
        .STEP        (8),
        .MAX_PER_LINE(2)
    ) dut (
        .clk_draw     (clk_draw),
        .rst_draw_n   (rst_draw_n),
        .line_i       (line_i),
        .enable_i     (enable_i),
        .match_req_o  (match_req_o),
        .match_idx_o  (match_idx_o),
        .match_valid_i(match_valid_i),
        .match_hit_i  (match_hit_i),
        .match_count_i(match_count_i),
        .match_lbx_i  (match_lbx_i),
        .match_map_i  (match_map_i),
        .match_bmp_i  (match_bmp_i),
        .slot_valid_o (slot_valid_o),
        .slot_ready_i (slot_ready_i),
        .slot_lbx_o   (slot_lbx_o),
        .slot_map_o   (slot_map_o),
        .slot_bmp_o   (slot_bmp_o),
        .slot_half_o  (slot_half_o),
        .slot_last_o  (slot_last_o),
        .busy_o       (busy_o),
        .line_done_o  (line_done_o),
        .overflow_o   (overflow_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Matcher model configuration
    int            lat     = 1;
    int            hit_idx = -1;
    bit            hit_all = 1'b0;
    int            budget  = 1000000;
    logic [CW-1:0] r_cnt   = '0;
    logic [LW-1:0] r_lbx   = '0;
    logic [MW-1:0] r_map   = '0;
    logic [BW-1:0] r_bmp   = '0;

    // Ready driver configuration
    bit rdy_toggle = 1'b0;
    bit rdy_level  = 1'b1;

    // Monitor state
    slot_t slots[$];
    int    reqs[$];
    int    n_done     = 0;
    bit    chk_stable = 1'b0;

    function automatic slot_t mk(input int lbx, input int map, input int bmp,
                                 input bit half, input bit last);
        return {LW'(lbx), MW'(map), BW'(bmp), half, last};
    endfunction

    function automatic slot_t slot_at(input int i);
        if (i < slots.size()) return slots[i];
        return '1;
    endfunction

    function automatic int req_at(input int i);
        if (i < reqs.size()) return reqs[i];
        return -1;
    endfunction

    // Matcher: answers each request after lat cycles
    initial begin : matcher
        int pend;
        int pend_idx;
        pend = 0;
        pend_idx = 0;
        match_valid_i = 1'b0;
        match_hit_i   = 1'b0;
        match_count_i = '0;
        match_lbx_i   = '0;
        match_map_i   = '0;
        match_bmp_i   = '0;
        forever begin
            @(posedge clk_draw);
            #1;
            match_valid_i = 1'b0;
            match_hit_i   = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    match_valid_i = 1'b1;
                    if ((hit_all || pend_idx == hit_idx) && budget > 0) begin
                        match_hit_i = 1'b1;
                        budget--;
                    end
                    match_count_i = r_cnt;
                    match_lbx_i   = r_lbx;
                    match_map_i   = r_map;
                    match_bmp_i   = r_bmp;
                end
            end
            if (match_req_o) begin
                pend_idx = int'(match_idx_o);
                pend     = lat;
            end
        end
    end

    initial begin : ready_drv
        slot_ready_i = 1'b1;
        forever begin
            @(posedge clk_draw);
            #1;
            slot_ready_i = rdy_toggle ? ~slot_ready_i : rdy_level;
        end
    end

    initial begin : monitor
        bit    prev_stall;
        slot_t prev, cur;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_draw);
            cur = {slot_lbx_o, slot_map_o, slot_bmp_o, slot_half_o, slot_last_o};
            if (slot_valid_o && slot_ready_i) slots.push_back(cur);
            if (match_req_o) reqs.push_back(int'(match_idx_o));
            if (line_done_o) n_done++;
            if (chk_stable && prev_stall)
                check("stall_hold", {slot_valid_o, cur}, {1'b1, prev});
            prev_stall = slot_valid_o && !slot_ready_i;
            prev = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_draw);
        #1;
    endtask

    task automatic pulse_line();
        line_i = 1'b1;
        tick(1);
        line_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int c;
        c = 0;
        while (!line_done_o && c < limit) begin
            tick(1);
            c++;
        end
        check(tag, line_done_o, 1);
        tick(1);
    endtask

    task automatic clear_obs();
        slots.delete();
        reqs.delete();
        n_done = 0;
    endtask

    initial begin : main
        line_i     = 1'b0;
        enable_i   = 1'b0;
        rst_draw_n = 1'b0;
        tick(3);
        check("rst_req",   match_req_o, 0);
        check("rst_idx",   match_idx_o, 0);
        check("rst_valid", slot_valid_o, 0);
        check("rst_slot",  {slot_lbx_o, slot_map_o, slot_bmp_o, slot_half_o, slot_last_o}, 0);
        check("rst_flags", {busy_o, line_done_o, overflow_o}, 0);
        rst_draw_n = 1'b1;
        enable_i   = 1'b1;
        tick(2);

        // Single hit on idx 3, count 2, ready always high
        hit_idx = 3; r_cnt = 2; r_lbx = 100; r_map = 40; r_bmp = 500;
        clear_obs();
        pulse_line();
        check("req_not_yet", match_req_o, 0);
        check("busy_run", busy_o, 1);
        tick(1);
        check("line_to_req", {match_req_o, match_idx_o}, {1'b1, 9'd0});
        wait_done("t1_done", 5000);
        check("t1_nslots", slots.size(), 4);
        check("t1_s0", slot_at(0), mk(100, 40, 500, 0, 0));
        check("t1_s1", slot_at(1), mk(108, 40, 500, 1, 0));
        check("t1_s2", slot_at(2), mk(116, 41, 500, 0, 0));
        check("t1_s3", slot_at(3), mk(124, 41, 500, 1, 1));
        check("t1_nreq", reqs.size(), 512);
        check("t1_lastreq", req_at(511), 511);
        check("t1_ndone", n_done, 1);
        check("t1_idle_busy", busy_o, 0);

        // Same sprite with ready toggling every cycle
        clear_obs();
        rdy_toggle = 1'b1;
        chk_stable = 1'b1;
        pulse_line();
        wait_done("t2_done", 5000);
        chk_stable = 1'b0;
        rdy_toggle = 1'b0;
        tick(1);
        check("t2_nslots", slots.size(), 4);
        check("t2_s0", slot_at(0), mk(100, 40, 500, 0, 0));
        check("t2_s1", slot_at(1), mk(108, 40, 500, 1, 0));
        check("t2_s2", slot_at(2), mk(116, 41, 500, 0, 0));
        check("t2_s3", slot_at(3), mk(124, 41, 500, 1, 1));

        // Line-buffer x wraps past 4095
        r_cnt = 1; r_lbx = 4090;
        clear_obs();
        pulse_line();
        wait_done("t3_done", 5000);
        check("t3_nslots", slots.size(), 2);
        check("t3_s0", slot_at(0), mk(4090, 40, 500, 0, 0));
        check("t3_s1", slot_at(1), mk(2, 40, 500, 1, 1));

        // Hit with count 0 on idx 0 behaves as a miss
        hit_idx = 0; r_cnt = 0;
        clear_obs();
        pulse_line();
        wait_done("t4_done", 5000);
        check("t4_nslots", slots.size(), 0);
        check("t4_req0", req_at(0), 0);
        check("t4_req1", req_at(1), 1);

        // line_i while WAIT: the late (hit) response is swallowed
        hit_idx = 0; r_cnt = 2; r_lbx = 100; budget = 1; lat = 6;
        clear_obs();
        pulse_line();
        tick(1);
        check("t5_in_wait", match_req_o, 1);
        pulse_line();
        lat = 1;
        wait_done("t5_done", 5000);
        check("t5_nslots", slots.size(), 0);
        check("t5_req0", req_at(0), 0);
        check("t5_req1", req_at(1), 0);
        check("t5_nreq", reqs.size(), 513);
        check("t5_budget", budget, 0);
        budget = 1000000;
        hit_idx = -1;

        // enable_i low parks the walker
        clear_obs();
        pulse_line();
        tick(3);
        enable_i = 1'b0;
        tick(4);
        check("t6_parked", {busy_o, match_req_o, slot_valid_o}, 0);
        check("t6_nodone", n_done, 0);
        enable_i = 1'b1;
        tick(1);

        // Every sprite hits with count 1
        hit_all = 1'b1; r_cnt = 1; r_lbx = 0; r_map = 7; r_bmp = 9;
        clear_obs();
        pulse_line();
        wait_done("t7_done", 20000);
`ifdef SPRITE_SEQ_LIMIT_EN
        check("t7_nslots", slots.size(), 4);
        check("t7_s3", slot_at(3), mk(8, 7, 9, 1, 1));
        check("t7_nreq", reqs.size(), 2);
        check("t7_ovf", overflow_o, 1);
        check("t7_ndone", n_done, 1);
        pulse_line();
        check("t7_ovf_clr", overflow_o, 0);
        enable_i = 1'b0;
        tick(8);
`else
        check("t7_nslots", slots.size(), 1024);
        check("t7_s1023", slot_at(1023), mk(8, 7, 9, 1, 1));
        check("t7_nreq", reqs.size(), 512);
        check("t7_ovf", overflow_o, 0);
        check("t7_ndone", n_done, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
